axi_reg_bank: RTL

- Parametrised AXI slave register bank: NUM_REGS registers of DATA_W bits, single-beat writes and reads.
- Adds byte-strobe writes, ID echo on B/R, address decode with SLVERR on out-of-range, and a full read channel.
- Sits behind the interconnect as the control/status register block for counter and peripheral logic.

---
 rtl/axi_reg_bank.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/axi_reg_bank.sv
// axi_reg_bank: AXI slave control/status register bank.
// NUM_REGS registers of DATA_W bits, single-beat reads and writes with byte
// strobes, ID echo on B/R and SLVERR on out-of-range addresses or wlast=0.
// Optional feature macro: AXI_REG_BANK_EXPORT_EN adds the flattened regs_o
// port carrying the live register contents.
module axi_reg_bank #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int ID_W     = 4,
  parameter int NUM_REGS = 8
) (
  input  logic                  clk,
  input  logic                  areset,
  input  logic [ID_W-1:0]       awid_i,
  input  logic [ADDR_W-1:0]     awaddr_i,
  input  logic                  awvalid_i,
  output logic                  awready_o,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic [DATA_W/8-1:0]   wstrb_i,
  input  logic                  wlast_i,
  input  logic                  wvalid_i,
  output logic                  wready_o,
  output logic [ID_W-1:0]       bid_o,
  output logic [1:0]            bresp_o,
  output logic                  bvalid_o,
  input  logic                  bready_i,
  input  logic [ID_W-1:0]       arid_i,
  input  logic [ADDR_W-1:0]     araddr_i,
  input  logic                  arvalid_i,
  output logic                  arready_o,
  output logic [ID_W-1:0]       rid_o,
  output logic [DATA_W-1:0]     rdata_o,
  output logic [1:0]            rresp_o,
  output logic                  rlast_o,
  output logic                  rvalid_o,
  input  logic                  rready_i
`ifdef AXI_REG_BANK_EXPORT_EN
  ,
  output logic [NUM_REGS*DATA_W-1:0] regs_o
`endif
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(NUM_REGS);
  localparam int SEL_W  = IDX_W + OFF_W;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
  typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;

  wr_state_t wr_state;
  rd_state_t rd_state;

  logic [DATA_W-1:0] mem [NUM_REGS];

  logic              aw_got;
  logic              w_got;
  logic [ID_W-1:0]   aw_id_q;
  logic [ADDR_W-1:0] aw_addr_q;
  logic [DATA_W-1:0] w_data_q;
  logic [STRB_W-1:0] w_strb_q;
  logic              w_last_q;

  // Anything above the register index field must be zero to hit the bank.
  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return (addr >> SEL_W) == '0;
  endfunction

  logic              aw_hs;
  logic              w_hs;
  logic              ar_hs;
  logic              commit;
  logic [ID_W-1:0]   wr_id;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [STRB_W-1:0] wr_strb;
  logic              wr_last;
  logic              wr_ok;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;
  logic              rd_ok;

  // A channel captured earlier wins over the live bus; otherwise the
  // handshake happening on this edge supplies the value.
  assign aw_hs   = awvalid_i && awready_o;
  assign w_hs    = wvalid_i && wready_o;
  assign ar_hs   = arvalid_i && arready_o;
  assign wr_id   = aw_got ? aw_id_q   : awid_i;
  assign wr_addr = aw_got ? aw_addr_q : awaddr_i;
  assign wr_data = w_got  ? w_data_q  : wdata_i;
  assign wr_strb = w_got  ? w_strb_q  : wstrb_i;
  assign wr_last = w_got  ? w_last_q  : wlast_i;
  assign commit  = (wr_state == WR_IDLE) && (aw_got || aw_hs) && (w_got || w_hs);
  assign wr_ok   = in_range(wr_addr) && wr_last;
  assign wr_idx  = wr_addr[SEL_W-1:OFF_W];
  assign rd_idx  = araddr_i[SEL_W-1:OFF_W];
  assign rd_ok   = in_range(araddr_i);

  // Write path: collect AW and W in any order, commit the strobed bytes, then hold B until accepted.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      wr_state  <= WR_IDLE;
      aw_got    <= 1'b0;
      w_got     <= 1'b0;
      aw_id_q   <= '0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      w_last_q  <= 1'b0;
      awready_o <= 1'b1;
      wready_o  <= 1'b1;
      bvalid_o  <= 1'b0;
      bid_o     <= '0;
      bresp_o   <= RESP_OKAY;
      for (int i = 0; i < NUM_REGS; i++) begin
        mem[i] <= '0;
      end
    end else begin
      case (wr_state)
        WR_IDLE: begin
          if (commit) begin
            if (wr_ok) begin
              for (int k = 0; k < STRB_W; k++) begin
                if (wr_strb[k]) begin
                  mem[wr_idx][k*8 +: 8] <= wr_data[k*8 +: 8];
                end
              end
            end
            bid_o     <= wr_id;
            bresp_o   <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            bvalid_o  <= 1'b1;
            awready_o <= 1'b0;
            wready_o  <= 1'b0;
            aw_got    <= 1'b0;
            w_got     <= 1'b0;
            wr_state  <= WR_RESP;
          end else begin
            if (aw_hs) begin
              aw_got    <= 1'b1;
              aw_id_q   <= awid_i;
              aw_addr_q <= awaddr_i;
              awready_o <= 1'b0;
            end
            if (w_hs) begin
              w_got    <= 1'b1;
              w_data_q <= wdata_i;
              w_strb_q <= wstrb_i;
              w_last_q <= wlast_i;
              wready_o <= 1'b0;
            end
          end
        end
        WR_RESP: begin
          if (bready_i) begin
            bvalid_o  <= 1'b0;
            awready_o <= 1'b1;
            wready_o  <= 1'b1;
            wr_state  <= WR_IDLE;
          end
        end
        default: wr_state <= WR_IDLE;
      endcase
    end
  end

  // Read path: sample the register on the AR edge (pre-write value on a collision) and hold R until accepted.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      rd_state  <= RD_IDLE;
      arready_o <= 1'b1;
      rvalid_o  <= 1'b0;
      rid_o     <= '0;
      rdata_o   <= '0;
      rresp_o   <= RESP_OKAY;
      rlast_o   <= 1'b0;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          if (ar_hs) begin
            rdata_o   <= rd_ok ? mem[rd_idx] : '0;
            rresp_o   <= rd_ok ? RESP_OKAY : RESP_SLVERR;
            rid_o     <= arid_i;
            rlast_o   <= 1'b1;
            rvalid_o  <= 1'b1;
            arready_o <= 1'b0;
            rd_state  <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (rready_i) begin
            rvalid_o  <= 1'b0;
            rlast_o   <= 1'b0;
            arready_o <= 1'b1;
            rd_state  <= RD_IDLE;
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

`ifdef AXI_REG_BANK_EXPORT_EN
  // Expose the register storage directly so the export has the same timing.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_export
    assign regs_o[gi*DATA_W +: DATA_W] = mem[gi];
  end
`endif

endmodule
